imem_fill: RTL and testbench
============================

Name: imem_fill

Overview:
- Line-fill engine directly upstream of the instruction cache.
- On a cache miss (b_rd high), fetches one 1024-bit line from the memory port as a burst of 64-bit beats and assembles it.
- Presents the line on b_data with a one-cycle b_dv strobe, which the cache writes into the victim way.
- Suppresses stale fills: if the fetch address moves during a burst, that line is never presented.

Parameters:
- XLEN, 64, address width.
- BEAT_W, 64, memory data beat width.
- LINE_W, 1024, cache line width; must equal BEATS*BEAT_W.
- BEATS, 16, beats per line (LINE_W/BEAT_W).
- OFFS_W, 7, line byte-offset width (log2(LINE_W/8)).

Ports:
- clk  in  1  clock, rising edge.
- clr_n  in  1  reset, asynchronous, active-low.
- pc  in  XLEN  current fetch address, same signal the cache indexes with.
- b_rd  in  1  miss request from cache (level; high while missing).
- b_data  out  LINE_W  assembled line.
- b_dv  out  1  line valid strobe, one cycle.
- m_addr  out  XLEN  burst base address, line-aligned.
- m_req  out  1  burst request.
- m_gnt  in  1  memory accepted request.
- m_data  in  BEAT_W  beat data.
- m_dv  in  1  beat valid.

Behaviour:
- Reset (async, clr_n=0): state=IDLE, beat counter=0, line_q=0, b_data=0, b_dv=0, m_req=0, m_addr=0. Reset mid-burst abandons the burst; memory beats arriving after release are ignored until a new REQ/grant.
- States: IDLE, REQ, BEAT, DONE; 2-bit state register.
- IDLE: if b_rd=1 at the edge:
  - line_q <= pc[XLEN-1:OFFS_W].
  - m_addr <= {pc[XLEN-1:OFFS_W], OFFS_W'b0}.
  - m_req <= 1.
  - Go to REQ.
- REQ: m_req held high and m_addr stable until m_gnt=1 is sampled. On that edge: m_req <= 0, counter <= 0, go to BEAT. m_gnt in any other state is ignored.
- BEAT:
  - Each edge with m_dv=1: b_data[BEAT_W*cnt +: BEAT_W] <= m_data; cnt <= cnt+1.
  - Beat k corresponds to byte address m_addr + 8k; ascending order, no critical-word-first.
  - On the edge that captures beat BEATS-1: counter wraps to 0, go to DONE.
  - m_dv=0 cycles stall without side effect. m_dv in IDLE, REQ or DONE is ignored.
- DONE (exactly one cycle, then IDLE unconditionally):
  - b_dv = (state==DONE) && b_rd && (pc[XLEN-1:OFFS_W]==line_q); decoded from registered state.
  - b_data is stable throughout DONE and holds until the next burst's first beat overwrites it.
- Stale fill: if b_rd dropped or pc moved to another line during REQ/BEAT, the burst still completes (no cancel on memory side) but b_dv stays 0. IDLE then re-requests on the next cycle if b_rd is high for the new line.
- Same-line pc change (offset only) is not stale; b_dv fires.
- Back-to-back: after a valid b_dv the cache hits on the following cycle and b_rd drops, so IDLE does not re-request. If b_rd is still high (different line), a new REQ starts the cycle after DONE.
- Minimum miss latency (m_gnt immediate, m_dv every cycle):
  - cycle 0: b_rd rises.
  - cycle 1: REQ, m_req=1.
  - cycles 2..17: 16 beats.
  - cycle 18: DONE, b_dv=1.
- Counter is $clog2(BEATS) bits and wraps naturally; no overflow state exists.

Decomposition:
- Shared header rv6_defs.vh holds:
  - localparams IMF_IDLE=2'd0, IMF_REQ=2'd1, IMF_BEAT=2'd2, IMF_DONE=2'd3;
  - LINE_W, BEAT_W, OFFS_W constants, shared with imem.
- No sub-module; the beat counter and shift-in are inline.

Test Plan:
- Single miss, pc=0x1000_0084, m_gnt after 2 cycles, m_dv every cycle, beat k data=k -> m_addr=0x1000_0080; exactly one b_dv at cycle 20; b_data[64k+:64]=k for k=0..15.
- Beats with m_dv gaps (pattern 1,0,0,1...) -> b_data identical to gapless run; b_dv only after 16th valid beat; no extra beat captured.
- pc changes 0x2000->0x3000 at beat 5 with b_rd held -> first burst completes with b_dv=0; new m_req with m_addr=0x3000 the cycle after DONE; b_dv=1 after second burst.
- b_rd drops at beat 8 -> burst completes, b_dv never asserted, FSM returns to IDLE, m_req stays 0.
- clr_n pulsed low at beat 10 (asynchronous, mid-cycle) -> all outputs 0 immediately; stray m_dv beats after release ignored; fresh b_rd gives a clean fill with b_data matching new data.
- pc offset moves 0x40->0x7C within the same line during fill -> b_dv=1; spurious m_gnt/m_dv in IDLE -> no state change.

Source files
------------

// File: rtl/imem_fill_pkg.sv
// Shared constants and state encoding for the instruction-cache line-fill engine.
// The same constants size the cache line on the imem side.
`timescale 1ns/1ps
package imem_fill_pkg;

  localparam int IMF_XLEN   = 64;
  localparam int IMF_BEAT_W = 64;
  localparam int IMF_LINE_W = 1024;
  localparam int IMF_BEATS  = IMF_LINE_W / IMF_BEAT_W;
  localparam int IMF_OFFS_W = 7;

  typedef enum logic [1:0] {
    IMF_IDLE = 2'd0,
    IMF_REQ  = 2'd1,
    IMF_BEAT = 2'd2,
    IMF_DONE = 2'd3
  } imf_state_e;

endpackage

// File: rtl/imem_fill.sv
// Line-fill engine: fetches one cache line as a burst of beats on a cache miss
// and presents it with a one-cycle strobe, dropping fills that went stale.
`timescale 1ns/1ps
module imem_fill
  import imem_fill_pkg::*;
#(
  parameter int XLEN   = IMF_XLEN,
  parameter int BEAT_W = IMF_BEAT_W,
  parameter int LINE_W = IMF_LINE_W,
  parameter int BEATS  = IMF_BEATS,
  parameter int OFFS_W = IMF_OFFS_W
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [XLEN-1:0]   pc,
  input  logic              b_rd,
  output logic [LINE_W-1:0] b_data,
  output logic              b_dv,
  output logic [XLEN-1:0]   m_addr,
  output logic              m_req,
  input  logic              m_gnt,
  input  logic [BEAT_W-1:0] m_data,
  input  logic              m_dv,
  output imf_state_e        dbg_state
);

  localparam int CNT_W = $clog2(BEATS);
  localparam int TAG_W = XLEN - OFFS_W;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  // Handshakes: m_req is held with a stable m_addr until m_gnt is sampled high;
  // m_dv qualifies m_data only while in BEAT; b_dv qualifies b_data for one cycle.

  imf_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [TAG_W-1:0] line_q;
  logic [TAG_W-1:0] pc_line;
  logic             unused_pc_offs;

  assign pc_line        = pc[XLEN-1:OFFS_W];
  assign unused_pc_offs = ^pc[OFFS_W-1:0];
  assign dbg_state      = state_q;

  // A fill is only presented if the cache is still missing on the same line.
  assign b_dv = (state_q == IMF_DONE) && b_rd && (pc_line == line_q);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state_q <= IMF_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IMF_IDLE: if (b_rd)  state_d = IMF_REQ;
      IMF_REQ:  if (m_gnt) state_d = IMF_BEAT;
      IMF_BEAT: if (m_dv && (cnt_q == LAST_BEAT)) state_d = IMF_DONE;
      IMF_DONE: state_d = IMF_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q  <= '0;
      line_q <= '0;
      b_data <= '0;
      m_addr <= '0;
      m_req  <= 1'b0;
    end else begin
      case (state_q)
        IMF_IDLE: begin
          if (b_rd) begin
            line_q <= pc_line;
            m_addr <= {pc_line, {OFFS_W{1'b0}}};
            m_req  <= 1'b1;
          end
        end
        IMF_REQ: begin
          if (m_gnt) begin
            m_req <= 1'b0;
            cnt_q <= '0;
          end
        end
        IMF_BEAT: begin
          // Beats arrive in ascending address order; the counter wraps to 0 on the last one.
          if (m_dv) begin
            b_data[BEAT_W*cnt_q +: BEAT_W] <= m_data;
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        IMF_DONE: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fill.sv
// Bench for imem_fill: a behavioural memory responder feeds bursts and records the
// line it delivered; directed and random fills are checked against that record.
`timescale 1ns/1ps
module tb_imem_fill;
  import imem_fill_pkg::*;

  logic          clk = 1'b0;
  logic          clr_n = 1'b1;
  logic [63:0]   pc = '0;
  logic          b_rd = 1'b0;
  logic [1023:0] b_data;
  logic          b_dv;
  logic [63:0]   m_addr;
  logic          m_req;
  logic          m_gnt = 1'b0;
  logic [63:0]   m_data = '0;
  logic          m_dv = 1'b0;
  imf_state_e    dbg_state;

  imem_fill dut (
    .clk(clk), .clr_n(clr_n), .pc(pc), .b_rd(b_rd),
    .b_data(b_data), .b_dv(b_dv), .m_addr(m_addr), .m_req(m_req),
    .m_gnt(m_gnt), .m_data(m_data), .m_dv(m_dv), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // responder configuration and its record of what it delivered
  int  gnt_delay = 0;
  int  gap_mode = 0;
  int  data_mode = 0;
  bit  spur_en = 1'b0;
  int  bursts_done = 0;
  int  beat_total = 0;
  int  slots_used = 0;
  logic [1023:0] exp_q[$];
  logic [63:0]   addr_q[$];

  initial begin : mem_responder
    logic [1023:0] line;
    logic [63:0]   d;
    int            k;
    int            slot;
    bit            v;
    forever begin
      forever begin
        m_gnt  = spur_en;
        m_dv   = spur_en;
        m_data = {$urandom, $urandom};
        @(posedge clk); #1;
        if (m_req === 1'b1 && !spur_en) break;
      end
      m_gnt = 1'b0;
      m_dv  = 1'b0;
      repeat (gnt_delay) begin @(posedge clk); #1; end
      m_gnt = 1'b1;
      addr_q.push_back(m_addr);
      @(posedge clk); #1;
      m_gnt = 1'b0;
      k = 0; slot = 0; line = '0;
      while (k < 16) begin
        case (gap_mode)
          0:       v = 1'b1;
          1:       v = (slot % 3 == 0);
          default: v = 1'($urandom_range(0, 1));
        endcase
        d = (data_mode == 0) ? 64'(k) : {$urandom, $urandom};
        m_dv = v;
        m_data = d;
        @(posedge clk);
        if (v) begin
          line[64*k +: 64] = d;
          k++;
          beat_total++;
        end
        slot++;
        #1;
      end
      m_dv = 1'b0;
      slots_used = slot;
      exp_q.push_back(line);
      bursts_done++;
    end
  end

  // strobe monitor
  int dv_cnt = 0;
  int dv_cyc = 0;
  always @(negedge clk) begin
    if (clr_n && b_dv === 1'b1) begin
      dv_cnt++;
      dv_cyc = cyc;
    end
  end

  int n_total = 0;
  int n_pass = 0;

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_line(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    for (int k = 0; k < 16; k++)
      chk($sformatf("%s[%0d]", tag, k), obs[64*k +: 64], exp[64*k +: 64]);
  endtask

  task automatic wait_beats(input int target);
    int n;
    n = 0;
    while (beat_total < target && n < 400) begin tick(); n++; end
    chk("beat_wait", 64'(beat_total >= target), 64'd1);
  endtask

  task automatic wait_bursts(input int target);
    int n;
    n = 0;
    while (bursts_done < target && n < 400) begin tick(); n++; end
    chk("burst_wait", 64'(bursts_done >= target), 64'd1);
  endtask

  task automatic pop_exp(output logic [1023:0] l);
    chk("exp_q_nonempty", 64'(exp_q.size() > 0), 64'd1);
    l = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
  endtask

  task automatic pop_addr(output logic [63:0] a);
    chk("addr_q_nonempty", 64'(addr_q.size() > 0), 64'd1);
    a = (addr_q.size() > 0) ? addr_q.pop_front() : '0;
  endtask

  // driver task: one complete miss with optional pc move or b_rd drop mid-burst
  task automatic do_fill(input string tag, input logic [63:0] pc_v, input int gd, input int gm,
                         input int dm, input int chg_beat, input logic [63:0] new_pc,
                         input int drop_beat);
    int            c0, d0, b0, bt0;
    logic          exp_dv;
    logic [63:0]   a;
    logic [1023:0] l, kline;
    gnt_delay = gd; gap_mode = gm; data_mode = dm;
    d0 = dv_cnt; b0 = bursts_done; bt0 = beat_total;
    pc = pc_v; b_rd = 1'b1; c0 = cyc;
    exp_dv = 1'b1;
    if (chg_beat > 0) begin
      wait_beats(bt0 + chg_beat);
      pc = new_pc;
      exp_dv = ((new_pc >> 7) == (pc_v >> 7));
    end
    if (drop_beat > 0) begin
      wait_beats(bt0 + drop_beat);
      b_rd = 1'b0;
      exp_dv = 1'b0;
    end
    wait_bursts(b0 + 1);
    tick();
    chk({tag, "_dv_count"}, 64'(dv_cnt - d0), 64'(exp_dv));
    if (exp_dv) chk({tag, "_latency"}, 64'(dv_cyc - c0), 64'(2 + gd + slots_used));
    pop_addr(a);
    chk({tag, "_m_addr_ref"}, a, pc_v & ~64'h7F);
    pop_exp(l);
    chk_line({tag, "_b_data"}, b_data, l);
    if (dm == 0) begin
      for (int k = 0; k < 16; k++) kline[64*k +: 64] = 64'(k);
      chk_line({tag, "_beat_k"}, b_data, kline);
    end
    b_rd = 1'b0;
    tick(); tick();
    chk({tag, "_idle"}, 64'(dbg_state), 64'(IMF_IDLE));
    chk({tag, "_req_low"}, 64'(m_req), 64'd0);
    chk({tag, "_no_extra_dv"}, 64'(dv_cnt - d0), 64'(exp_dv));
  endtask

  initial begin : stimulus
    int            d0, b0, bt0;
    logic [63:0]   a, pc_r, npc;
    logic [1023:0] l, saved;
    int            mv;

    // reset values
    #3 clr_n = 1'b0;
    #1;
    chk("rst_b_dv", 64'(b_dv), 64'd0);
    chk("rst_m_req", 64'(m_req), 64'd0);
    chk("rst_m_addr", m_addr, 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(IMF_IDLE));
    chk_line("rst_b_data", b_data, '0);
    repeat (2) @(posedge clk);
    #2 clr_n = 1'b1;
    tick();

    // single miss, grant after 2 cycles, beat k carries k
    do_fill("miss1", 64'h1000_0084, 2, 0, 0, 0, '0, 0);
    // minimum latency with random data
    do_fill("minlat", 64'h0000_00AB_1234_5678, 0, 0, 1, 0, '0, 0);
    // gapped beats (1,0,0 pattern)
    do_fill("gaps", 64'h1000_0084, 0, 1, 0, 0, '0, 0);

    // pc moves to another line at beat 5; the next line is fetched afterwards
    gnt_delay = 1; gap_mode = 0; data_mode = 1;
    d0 = dv_cnt; b0 = bursts_done; bt0 = beat_total;
    pc = 64'h2000; b_rd = 1'b1;
    wait_beats(bt0 + 5);
    pc = 64'h3000;
    wait_bursts(b0 + 1);
    tick();
    chk("stale_dv", 64'(dv_cnt - d0), 64'd0);
    pop_addr(a);
    chk("stale_addr1", a, 64'h2000);
    pop_exp(l);
    chk_line("stale_b_data", b_data, l);
    tick();
    chk("stale_rereq", 64'(m_req), 64'd1);
    chk("stale_addr2_live", m_addr, 64'h3000);
    wait_bursts(b0 + 2);
    tick();
    chk("refill_dv", 64'(dv_cnt - d0), 64'd1);
    pop_addr(a);
    chk("refill_addr", a, 64'h3000);
    pop_exp(l);
    chk_line("refill_b_data", b_data, l);
    b_rd = 1'b0;
    tick();

    // b_rd drops at beat 8
    do_fill("drop", 64'h6000_0010, 1, 0, 1, 0, '0, 8);

    // asynchronous reset mid-burst, then stray beats
    gnt_delay = 0; gap_mode = 0; data_mode = 1;
    d0 = dv_cnt; b0 = bursts_done; bt0 = beat_total;
    pc = 64'h4000_0100; b_rd = 1'b1;
    wait_beats(bt0 + 10);
    #1 clr_n = 1'b0;
    #1;
    chk("arst_m_req", 64'(m_req), 64'd0);
    chk("arst_m_addr", m_addr, 64'd0);
    chk("arst_b_dv", 64'(b_dv), 64'd0);
    chk("arst_state", 64'(dbg_state), 64'(IMF_IDLE));
    chk_line("arst_b_data", b_data, '0);
    b_rd = 1'b0;
    #2 clr_n = 1'b1;
    wait_bursts(b0 + 1);
    repeat (3) tick();
    pop_addr(a);
    pop_exp(l);
    chk_line("stray_b_data", b_data, '0);
    chk("stray_state", 64'(dbg_state), 64'(IMF_IDLE));
    chk("stray_m_req", 64'(m_req), 64'd0);
    chk("stray_dv", 64'(dv_cnt - d0), 64'd0);
    do_fill("post_rst", 64'h4000_0100, 1, 2, 1, 0, '0, 0);

    // offset-only pc move is not stale
    do_fill("sameln", 64'h5000_0040, 1, 0, 1, 3, 64'h5000_007C, 0);

    // spurious grant/beat while idle
    saved = b_data; b0 = bursts_done;
    spur_en = 1'b1;
    repeat (3) tick();
    spur_en = 1'b0;
    repeat (2) tick();
    chk("spur_state", 64'(dbg_state), 64'(IMF_IDLE));
    chk("spur_m_req", 64'(m_req), 64'd0);
    chk("spur_no_burst", 64'(bursts_done - b0), 64'd0);
    chk_line("spur_b_data", b_data, saved);

    // randomized fills: random pc, grant delay, beat gaps, data and pc moves
    for (int i = 0; i < 4; i++) begin
      pc_r = {$urandom, $urandom};
      mv = $urandom_range(0, 2);
      npc = '0;
      if (mv == 1) npc = {pc_r[63:7], 7'($urandom)};
      if (mv == 2) npc = pc_r + 64'h80 * 64'($urandom_range(1, 100));
      do_fill($sformatf("rnd%0d", i), pc_r, $urandom_range(0, 3), 2, 1,
              (mv != 0) ? $urandom_range(1, 14) : 0, npc, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
